post_tu_1d_acc: RTL
===================

Name: post_tu_1d_acc

Overview:
- Streaming 1-D Winograd F(2,3) output post-transform (A^T) with channel accumulation.
- Inverse end of the 1-D input pre-transform; sits after the element-wise multiplier array in the SFTM datapath.
- Per input channel, accepts one 4-element product vector M0..M3 and sums the vectors over NCH channels.
- Once all NCH vectors are summed, applies A^T to produce 2 spatial outputs, delivered through a valid/ready output register.

Parameters:
- PW, 34: signed width of each product element M0..M3.
- NCH, 16: input channels accumulated per output group (>=1).
- CW, 4: channel counter width, equal to clog2(NCH) (minimum 1).
- AW, PW+CW: accumulator width per element.
- OW, AW+2: output width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  1 = RFConv transform; 0 = RFDeConv (reserved, outputs zero).
- in_valid  in  1  product vector valid.
- in_ready  out  1  block can accept a vector.
- M0, M1, M2, M3  in  PW each, signed  Winograd-domain products.
- out_valid  out  1  Y0/Y1 hold a completed group.
- out_ready  in  1  downstream accepts.
- Y0, Y1  out  OW each, signed  spatial outputs.
- grp_busy  out  1  a partial group is in progress (cnt != 0).

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - out_valid=0, Y0=Y1=0.
  - Accumulators A0..A3=0, cnt=0, mode_q=0, grp_busy=0.
  - in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - A beat transfers when in_valid & in_ready.
  - in_ready = ~out_valid | out_ready (one-deep output, pass-through ready). This is the only source of backpressure.
- Accepted beat, non-final (cnt < NCH-1):
  - Ai <= Ai + sext(Mi).
  - cnt <= cnt+1.
  - If cnt==0, mode_q <= mode. Mode is sampled at the first beat of a group; mode changes mid-group are ignored.
- Accepted beat, final (cnt == NCH-1):
  - Form Si = Ai + sext(Mi), full AW width.
  - Load Y0 <= S0 + S1 + S2 and Y1 <= S1 - S2 - S3, sign-extended to OW, no truncation.
  - If the effective mode is 0, load Y0=Y1=0 instead. The effective mode is mode when NCH==1, else mode_q.
  - Set out_valid=1.
  - Clear A0..A3=0 and cnt=0.
  - Latency: Y is valid the cycle after the final beat.
- Output register:
  - out_valid clears on out_valid & out_ready unless a new final beat loads in the same cycle, in which case it stays 1 with new data.
  - Y holds stable while out_valid & ~out_ready.
- Counter: counts 0..NCH-1 and wraps to 0 after the final beat. It never exceeds NCH-1.
- No-beat cycles: in_valid=0 leaves accumulators and cnt unchanged; gaps between beats are allowed.
- Arithmetic:
  - Two's complement throughout, no saturation.
  - AW guarantees no overflow over NCH beats; OW guarantees no overflow of the A^T sums.
- Reset mid-group: the partial sums are discarded and no output is produced.
- Reset with out_valid=1: the pending output is dropped.
- grp_busy = (cnt != 0); it is combinational from the registered cnt.

Decomposition:
- Package sftm_pkg holds:
  - MODE_RFCONV = 1'b1 and MODE_RFDECONV = 1'b0.
  - Tile constants: TILE_IN = 4, TILE_OUT = 2, KSIZE = 3.
  - A shared width helper, clog2.
- Sub-module post_tu_1d_core: purely combinational A^T (4 inputs of AW -> 2 outputs of OW, with mode gating). Instantiated once on the S vector; reusable for the 2-D column pass.

Test Plan:
- NCH=1 sanity, mode=1, M=(10,20,30,40) -> next cycle out_valid=1, Y0=60, Y1=-50.
- NCH=4, mode=1, four beats of M=(1,2,3,4) with a 2-cycle gap after beat 2 -> single output Y0=24, Y1=-20; grp_busy=1 only between beats 1 and 4.
- Signed extremes, NCH=16, each M=(-2^33, 2^33-1, -2^33, 2^33-1) -> Y0=16*(-2^34+2^33-1), Y1=16*(2^33-1+2^33-2^33+1); exact, no wrap.
- Backpressure: group done while out_ready=0 -> in_ready=0, Y held. Raise out_ready in the same cycle as a new final beat -> out_valid stays 1 and Y updates with no lost or duplicated group.
- Mode: mode=0 at the first beat, toggled to 1 mid-group -> Y0=Y1=0. Next group with mode=1 -> correct nonzero result.
- Reset: assert rst after 2 of 4 beats -> cnt=0, no output. A following full group of M=(1,1,1,1) gives Y0=12, Y1=-4.

Source files
------------

// File: rtl/sftm_pkg.sv
// Shared constants and width helpers for the SFTM Winograd datapath.
// Mode encodings, F(2,3) tile geometry and a constant-foldable ceil(log2).
package sftm_pkg;

   localparam logic MODE_RFCONV   = 1'b1;
   localparam logic MODE_RFDECONV = 1'b0;

   localparam int TILE_IN  = 4;
   localparam int TILE_OUT = 2;
   localparam int KSIZE    = 3;

   // Returns 0 for values <= 1, so callers clamp to a minimum of 1 where needed.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/post_tu_1d_acc_if.sv
// Product-vector input and spatial-output handshake bundle for post_tu_1d_acc.
// The slave modport is the accumulator's view; master is the driving/consuming side.
interface post_tu_1d_acc_if #(
   parameter int PW = 34,
   parameter int OW = 40
);

   logic                 mode;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [PW-1:0] M0;
   logic signed [PW-1:0] M1;
   logic signed [PW-1:0] M2;
   logic signed [PW-1:0] M3;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] Y0;
   logic signed [OW-1:0] Y1;

   modport slave (
      input  mode, in_valid, M0, M1, M2, M3, out_ready,
      output in_ready, out_valid, Y0, Y1
   );

   modport master (
      output mode, in_valid, M0, M1, M2, M3, out_ready,
      input  in_ready, out_valid, Y0, Y1
   );

endinterface

// File: rtl/post_tu_1d_core.sv
// Combinational 1-D F(2,3) output transform A^T: 4 Winograd-domain sums -> 2 spatial outputs.
// Outputs are forced to zero unless the mode is RFConv.
module post_tu_1d_core
   import sftm_pkg::*;
#(
   parameter int AW = 38,
   parameter int OW = 40
) (
   input  logic                 i_mode,
   input  logic signed [AW-1:0] i_s0,
   input  logic signed [AW-1:0] i_s1,
   input  logic signed [AW-1:0] i_s2,
   input  logic signed [AW-1:0] i_s3,
   output logic signed [OW-1:0] o_y0,
   output logic signed [OW-1:0] o_y1
);

   logic signed [OW-1:0] w_e0;
   logic signed [OW-1:0] w_e1;
   logic signed [OW-1:0] w_e2;
   logic signed [OW-1:0] w_e3;

   // Widen before combining so the three-term sums cannot wrap.
   assign w_e0 = {{(OW-AW){i_s0[AW-1]}}, i_s0};
   assign w_e1 = {{(OW-AW){i_s1[AW-1]}}, i_s1};
   assign w_e2 = {{(OW-AW){i_s2[AW-1]}}, i_s2};
   assign w_e3 = {{(OW-AW){i_s3[AW-1]}}, i_s3};

   assign o_y0 = (i_mode == MODE_RFCONV) ? (w_e0 + w_e1 + w_e2) : '0;
   assign o_y1 = (i_mode == MODE_RFCONV) ? (w_e1 - w_e2 - w_e3) : '0;

endmodule

// File: rtl/post_tu_1d_acc.sv
// Accumulates NCH product vectors per group, then applies A^T and presents
// the two spatial outputs through a one-deep valid/ready register.
module post_tu_1d_acc
   import sftm_pkg::*;
#(
   parameter int PW  = 34,
   parameter int NCH = 16,
   parameter int CW  = (clog2(NCH) < 1) ? 1 : clog2(NCH),
   parameter int AW  = PW + CW,
   parameter int OW  = AW + 2
) (
   input  logic             clk,
   input  logic             rst,
   post_tu_1d_acc_if.slave  bus,
   output logic             grp_busy
);

   logic signed [AW-1:0] r_acc [4];
   logic [CW-1:0]        r_cnt;
   logic                 r_modeQ;
   logic                 r_outValid;
   logic signed [OW-1:0] r_y0;
   logic signed [OW-1:0] r_y1;

   logic signed [AW-1:0] w_mExt [4];
   logic signed [AW-1:0] w_sum [4];
   logic signed [OW-1:0] w_y0;
   logic signed [OW-1:0] w_y1;
   logic                 w_inReady;
   logic                 w_accept;
   logic                 w_isFinal;
   logic                 w_effMode;

   assign w_mExt[0] = {{(AW-PW){bus.M0[PW-1]}}, bus.M0};
   assign w_mExt[1] = {{(AW-PW){bus.M1[PW-1]}}, bus.M1};
   assign w_mExt[2] = {{(AW-PW){bus.M2[PW-1]}}, bus.M2};
   assign w_mExt[3] = {{(AW-PW){bus.M3[PW-1]}}, bus.M3};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_sum[i] = r_acc[i] + w_mExt[i];
      end
   end

   assign w_inReady = ~r_outValid | bus.out_ready;
   assign w_accept  = bus.in_valid & w_inReady;
   assign w_isFinal = (r_cnt == CW'(NCH - 1));
   // A single-channel group has no earlier beat to latch the mode from.
   assign w_effMode = (NCH == 1) ? bus.mode : r_modeQ;

   post_tu_1d_core #(
      .AW (AW),
      .OW (OW)
   ) u_core (
      .i_mode (w_effMode),
      .i_s0   (w_sum[0]),
      .i_s1   (w_sum[1]),
      .i_s2   (w_sum[2]),
      .i_s3   (w_sum[3]),
      .o_y0   (w_y0),
      .o_y1   (w_y1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_acc[i] <= '0;
         end
         r_cnt      <= '0;
         r_modeQ    <= MODE_RFDECONV;
         r_outValid <= 1'b0;
         r_y0       <= '0;
         r_y1       <= '0;
      end else begin
         if (w_accept && w_isFinal) begin
            for (int i = 0; i < 4; i++) begin
               r_acc[i] <= '0;
            end
            r_cnt      <= '0;
            r_y0       <= w_y0;
            r_y1       <= w_y1;
            r_outValid <= 1'b1;
         end else begin
            if (w_accept) begin
               for (int i = 0; i < 4; i++) begin
                  r_acc[i] <= w_sum[i];
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == '0) begin
                  r_modeQ <= bus.mode;
               end
            end
            // A same-cycle final beat above takes priority over the drain.
            if (r_outValid && bus.out_ready) begin
               r_outValid <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.Y0        = r_y0;
   assign bus.Y1        = r_y1;
   assign grp_busy      = (r_cnt != '0);

endmodule
